// File: rtl/sr_cmd_arbiter_if.sv
// Command/bank bus between requesters, the SR flag bank and sr_cmd_arbiter.
//   req/op/idx : per-requester command (requester i uses idx[i*AW +: AW])
//   gnt        : one-hot grant pulse back to the requesters
//   s_out/r_out: set/reset drive into the SR bank
//   q_in       : q readback from the SR bank
// master = requesters + bank side, slave = arbiter side.
interface sr_cmd_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned AW    = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    op;
  logic [NREQ*AW-1:0] idx;
  logic [NREQ-1:0]    gnt;
  logic [NFLAG-1:0]   s_out;
  logic [NFLAG-1:0]   r_out;
  logic [NFLAG-1:0]   q_in;

  modport master (output req, op, idx, q_in, input gnt, s_out, r_out);
  modport slave  (input req, op, idx, q_in, output gnt, s_out, r_out);
endinterface

// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter sharing a bank of SR flags between NREQ requesters.
// One command per IDLE->DRIVE->CHECK pass: the winning set/clear is driven
// for exactly one cycle, then the flag readback is compared against it.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sr_cmd_arbiter_if slave (req/op/idx/gnt, s_out/r_out/q_in)
//   busy     : high whenever the FSM is not idle
//   err      : one-cycle pulse in CHECK on bad index or readback mismatch
//   err_cnt  : saturating error count
module sr_cmd_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  sr_cmd_arbiter_if.slave        bus,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             err_cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [IW-1:0]   win, win_d;
  logic            op_l, op_d;
  logic [AW-1:0]   idx_l, idx_d;
  logic            bad, bad_d;
  logic [NREQ-1:0] gnt_d;
  logic [NFLAG-1:0] s_d, r_d;
  logic            busy_d;
  logic [7:0]      err_cnt_d;
  logic            found;
  logic [IW-1:0]   cand;
  logic            q_sel;

  // Readback bit of the latched flag (0 when the index is out of range).
  always_comb begin
    q_sel = 1'b0;
    for (int unsigned f = 0; f < NFLAG; f++) begin
      if (32'(idx_l) == f) q_sel = bus.q_in[f];
    end
  end

  // The bank only shows the new q during CHECK, so err is decoded live.
  assign err = (state == CHECK) && (bad || (q_sel != op_l));

  // Next-state, arbitration and next-cycle output values.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    win_d     = win;
    op_d      = op_l;
    idx_d     = idx_l;
    bad_d     = bad;
    gnt_d     = '0;
    s_d       = '0;
    r_d       = '0;
    err_cnt_d = err_cnt;
    found     = 1'b0;
    cand      = '0;

    case (state)
      IDLE: begin
        // First requester at or after ptr, wrapping.
        for (int unsigned k = 0; k < NREQ; k++) begin
          cand = IW'((32'(ptr) + k) % NREQ);
          if (!found && bus.req[cand]) begin
            found = 1'b1;
            win_d = cand;
          end
        end
        if (found) begin
          op_d    = bus.op[win_d];
          idx_d   = bus.idx[32'(win_d)*AW +: AW];
          bad_d   = (32'(idx_d) >= NFLAG);
          gnt_d   = NREQ'(1) << win_d;
          for (int unsigned f = 0; f < NFLAG; f++) begin
            if (32'(idx_d) == f) begin
              s_d[f] = op_d;
              r_d[f] = ~op_d;
            end
          end
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (err && (err_cnt != 8'hFF)) err_cnt_d = err_cnt + 8'd1;
        ptr_d   = IW'((32'(win) + 1) % NREQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      op_l      <= 1'b0;
      idx_l     <= '0;
      bad       <= 1'b0;
      err_cnt   <= '0;
      busy      <= 1'b0;
      bus.gnt   <= '0;
      bus.s_out <= '0;
      bus.r_out <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      win       <= win_d;
      op_l      <= op_d;
      idx_l     <= idx_d;
      bad       <= bad_d;
      err_cnt   <= err_cnt_d;
      busy      <= busy_d;
      bus.gnt   <= gnt_d;
      bus.s_out <= s_d;
      bus.r_out <= r_d;
    end
  end

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Self-checking bench for sr_cmd_arbiter: an 8-flag instance under directed
// and random traffic against a command-level reference model, plus a 6-flag
// instance for out-of-range indices and error-count saturation.
module tb_sr_cmd_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned NFLAG   = 8;
  localparam int unsigned NFLAG_B = 6;
  localparam int unsigned AW      = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_b;
  logic       busy, err, busy_b, err_b;
  logic [7:0] err_cnt, err_cnt_b;

  sr_cmd_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG),   .AW(AW)) a_if ();
  sr_cmd_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG_B), .AW(AW)) b_if ();

  sr_cmd_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .busy(busy), .err(err), .err_cnt(err_cnt)
  );

  sr_cmd_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG_B), .AW(AW)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave),
    .busy(busy_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  // SR bank plant: registered flags, optional stuck-at-1 fault mask.
  logic [NFLAG-1:0] bank  = '0;
  logic [NFLAG-1:0] stuck = '0;
  assign a_if.q_in = bank | stuck;
  assign b_if.q_in = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: command age 0 = idle, 1 = granted/driving, 2 = checking.
  int   m_age    = 0;
  int   m_ptr    = 0;
  int   m_win    = 0;
  int   m_idx    = 0;
  int   m_errcnt = 0;
  logic m_op     = 1'b0;
  logic m_errexp = 1'b0;

  logic [NREQ-1:0] gq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compare outputs with the model, advance the model over one edge, update the bank.
  task automatic step();
    logic [NREQ-1:0]  exp_g;
    logic [NFLAG-1:0] exp_s, exp_r, s_obs, r_obs;
    exp_g = '0; exp_s = '0; exp_r = '0;
    if (m_age == 1) begin
      exp_g[m_win] = 1'b1;
      if (m_op) exp_s[m_idx] = 1'b1;
      else      exp_r[m_idx] = 1'b1;
    end
    check("gnt",     32'(a_if.gnt),   32'(exp_g));
    check("s_out",   32'(a_if.s_out), 32'(exp_s));
    check("r_out",   32'(a_if.r_out), 32'(exp_r));
    check("busy",    32'(busy),       32'(m_age != 0));
    check("err",     32'(err),        32'((m_age == 2) && m_errexp));
    check("err_cnt", 32'(err_cnt),    32'(m_errcnt));
    check("sr_excl", 32'(a_if.s_out & a_if.r_out), 32'(0));
    check("sr_one",  32'($countones(a_if.s_out | a_if.r_out) <= 1), 32'(1));
    if (a_if.gnt != '0) gq.push_back(a_if.gnt);
    s_obs = a_if.s_out;
    r_obs = a_if.r_out;

    if (rst) begin
      m_age = 0; m_ptr = 0; m_errcnt = 0;
    end else begin
      case (m_age)
        0: begin
          for (int k = 0; k < NREQ; k++) begin
            if (m_age == 0 && a_if.req[(m_ptr + k) % NREQ]) begin
              m_win = (m_ptr + k) % NREQ;
              m_age = 1;
            end
          end
          if (m_age == 1) begin
            m_op     = a_if.op[m_win];
            m_idx    = int'(a_if.idx[m_win*AW +: AW]);
            m_errexp = stuck[m_idx] && !m_op;
          end
        end
        1: m_age = 2;
        default: begin
          if (m_errexp && m_errcnt < 255) m_errcnt++;
          m_ptr = (m_win + 1) % NREQ;
          m_age = 0;
        end
      endcase
    end

    @(posedge clk);
    #1;
    bank = (bank | s_obs) & ~r_obs;
    @(negedge clk);
  endtask

  // Random requesters: drop req once granted, raise new commands at random.
  task automatic drive_reqs();
    if (m_age == 1) a_if.req[m_win] = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!a_if.req[i] && !(m_age == 1 && i == m_win) && $urandom_range(0, 3) == 0) begin
        a_if.req[i] = 1'b1;
        a_if.op[i]  = 1'($urandom);
        a_if.idx[i*AW +: AW] = AW'($urandom_range(0, NFLAG - 1));
      end
    end
    if (m_age == 0) stuck = ($urandom_range(0, 3) == 0) ? NFLAG'($urandom) : '0;
  endtask

  task automatic drain();
    a_if.req = '0;
    for (int t = 0; t < 10 && m_age != 0; t++) step();
    step();
    check("drain_idle", 32'(busy), 32'(0));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    rst_b = 1'b1;
    a_if.req = '1;
    a_if.op  = 4'b0110;
    a_if.idx = {3'd4, 3'd3, 3'd2, 3'd1};
    b_if.req = '0;
    b_if.op  = '0;
    b_if.idx = '0;
    @(negedge clk);

    // Reset with all requests high, then continuous requests rotate.
    step();
    step();
    rst = 1'b0;
    gq.delete();
    for (int c = 0; c < 15; c++) step();
    check("rot_count", 32'(gq.size()), 32'(5));
    for (int g = 0; g < 5 && g < gq.size(); g++)
      check("rot_order", 32'(gq[g]), 32'(1 << (g % NREQ)));
    drain();

    // Single set of flag 5 by requester 0.
    a_if.req = 4'b0001;
    a_if.op[0] = 1'b1;
    a_if.idx[0 +: AW] = 3'd5;
    step();
    check("t2_gnt", 32'(a_if.gnt), 32'(4'b0001));
    check("t2_s",   32'(a_if.s_out), 32'(8'h20));
    check("t2_r",   32'(a_if.r_out), 32'(0));
    a_if.req = '0;
    step();
    check("t2_q5",  32'(a_if.q_in[5]), 32'(1));
    check("t2_err", 32'(err), 32'(0));
    step();

    // Clear of flag 6 against a bank stuck at 1.
    stuck = 8'h40;
    a_if.req = 4'b0100;
    a_if.op[2] = 1'b0;
    a_if.idx[2*AW +: AW] = 3'd6;
    step();
    check("t4_r", 32'(a_if.r_out), 32'(8'h40));
    a_if.req = '0;
    step();
    check("t4_err", 32'(err), 32'(1));
    step();
    check("t4_cnt", 32'(err_cnt), 32'(1));
    check("t4_err_once", 32'(err), 32'(0));
    stuck = '0;

    // Random traffic.
    for (int c = 0; c < 1200; c++) begin
      drive_reqs();
      step();
    end
    stuck = '0;
    drain();

    // Reset in DRIVE clears ptr: first grant afterwards goes to requester 0.
    a_if.op  = 4'b1010;
    a_if.idx = {3'd7, 3'd6, 3'd1, 3'd0};
    a_if.req = 4'b0010;
    step();
    a_if.req = '0;
    step();
    step();
    a_if.req = 4'b0100;
    step();
    check("t6_pre_gnt", 32'(a_if.gnt), 32'(4'b0100));
    rst = 1'b1;
    a_if.req = '1;
    step();
    rst = 1'b0;
    check("t6_gnt0",  32'(a_if.gnt), 32'(0));
    check("t6_sr0",   32'(a_if.s_out | a_if.r_out), 32'(0));
    check("t6_busy0", 32'(busy), 32'(0));
    check("t6_cnt0",  32'(err_cnt), 32'(0));
    step();
    check("t6_ptr0", 32'(a_if.gnt), 32'(4'b0001));
    drain();

    // 6-flag instance: out-of-range index, then error-count saturation.
    tick();
    rst_b = 1'b0;
    b_if.req = 4'b0010;
    b_if.op  = 4'b0010;
    b_if.idx = {3'd0, 3'd0, 3'd7, 3'd0};
    tick();
    check("t5_gnt",  32'(b_if.gnt), 32'(4'b0010));
    check("t5_sr",   32'(b_if.s_out | b_if.r_out), 32'(0));
    b_if.req = '0;
    tick();
    check("t5_err",  32'(err_b), 32'(1));
    check("t5_sr2",  32'(b_if.s_out | b_if.r_out), 32'(0));
    tick();
    check("t5_cnt",  32'(err_cnt_b), 32'(1));
    check("t5_idle", 32'(busy_b), 32'(0));

    b_if.req = '1;
    b_if.op  = 4'b0101;
    b_if.idx = {3'd7, 3'd6, 3'd7, 3'd6};
    for (int k = 1; k <= 260; k++) begin
      tick();
      tick();
      if (k % 20 == 0 || k > 252) check("sat_err", 32'(err_b), 32'(1));
      tick();
      check("sat_cnt", 32'(err_cnt_b), 32'((k + 1 > 255) ? 255 : k + 1));
    end
    b_if.req = '0;
    tick(); tick(); tick();
    check("sat_hold", 32'(err_cnt_b), 32'(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
